// File: rtl/digit_entry_accum.sv
`default_nettype none
// ============================================================================
// Module  : digit_entry_accum
// Brief   : Decimal keypad digit buffer with multi-cycle Horner binary convert.
// Revision: 1.0
// ============================================================================
module digit_entry_accum #(
   parameter int DIGITS = 3,
   parameter int WIDTH  = 10
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic                         key_ready,
   input  logic                         result_ack,
   output logic [WIDTH-1:0]             number,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         result_valid,
   output logic                         overflow
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENTRY  = 2'd1,
      S_CALC   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t           r_state;
   logic [3:0]       r_d [DIGITS];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_number;
   logic [IW-1:0]    r_idx;
   logic             r_result_valid;
   logic             r_overflow;

   logic             w_accept;
   logic [WIDTH+3:0] w_acc_ext;
   logic [WIDTH-1:0] w_step;

   assign key_ready    = (r_state == S_IDLE) || (r_state == S_ENTRY);
   assign w_accept     = key_valid && key_ready;
   assign number       = r_number;
   assign digit_count  = r_count;
   assign result_valid = r_result_valid;
   assign overflow     = r_overflow;

   // acc*10 built from shifts in a 4-bit-wider field; the WIDTH rule keeps the truncation lossless
   assign w_acc_ext = {4'd0, r_acc};
   assign w_step    = WIDTH'(((w_acc_ext << 3) + (w_acc_ext << 1)) + (WIDTH + 4)'(r_d[r_idx]));

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_count        <= '0;
         r_acc          <= '0;
         r_number       <= '0;
         r_idx          <= '0;
         r_result_valid <= 1'b0;
         r_overflow     <= 1'b0;
         for (int i = 0; i < DIGITS; i++) r_d[i] <= 4'd0;
      end else begin
         r_overflow <= 1'b0;
         case (r_state)
            S_IDLE, S_ENTRY: begin
               if (w_accept) begin
                  if (key_code <= 4'd9) begin
                     if (r_count == CW'(DIGITS)) begin
                        r_overflow <= 1'b1;
                     end else if (!(key_code == 4'd0 && r_count == '0)) begin
                        for (int i = DIGITS - 1; i > 0; i--) r_d[i] <= r_d[i-1];
                        r_d[0]  <= key_code;
                        r_count <= r_count + CW'(1);
                        r_acc   <= '0;
                        r_idx   <= IW'(DIGITS - 1);
                        r_state <= S_CALC;
                     end
                  end else if (key_code == 4'hA) begin
                     if (r_count != '0) begin
                        for (int i = 0; i < DIGITS - 1; i++) r_d[i] <= r_d[i+1];
                        r_d[DIGITS-1] <= 4'd0;
                        r_count       <= r_count - CW'(1);
                        r_acc         <= '0;
                        r_idx         <= IW'(DIGITS - 1);
                        r_state       <= S_CALC;
                     end
                  end else if (key_code == 4'hB) begin
                     for (int i = 0; i < DIGITS; i++) r_d[i] <= 4'd0;
                     r_count  <= '0;
                     r_number <= '0;
                     r_state  <= S_IDLE;
                  end else if (key_code == 4'hC) begin
                     if (r_count != '0) begin
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                     end
                  end
               end
            end
            S_CALC: begin
               // number is only written on the final step so it never shows a partial value
               r_acc <= w_step;
               if (r_idx == '0) begin
                  r_number <= w_step;
                  r_state  <= (r_count != '0) ? S_ENTRY : S_IDLE;
               end else begin
                  r_idx <= r_idx - IW'(1);
               end
            end
            S_RESULT: begin
               if (result_ack) begin
                  for (int i = 0; i < DIGITS; i++) r_d[i] <= 4'd0;
                  r_count        <= '0;
                  r_number       <= '0;
                  r_result_valid <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
